clock_sequencer: RTL and testbench

Synchronous replacement for the gated-clock path of the 8-bit computer: generates a one-cycle clock-enable pulse (`clk_en`) for all CPU registers from free-running, single-tick or single-instruction modes, debounces the manual step button, and owns the microstep ring counter that feeds the control-word decoder. Sits between the front-panel switches/button and the CPU core; the CPU runs entirely on `system_clock` qualified by `clk_en`.

---
 rtl/clock_sequencer.sv | 162 ++++++++++++++++
 tb/tb_clock_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_sequencer.sv
// Clock-enable sequencer for the 8-bit CPU: free-run, single-tick and single-instruction stepping.
// Optional ISTEP mode and busy flag are built only when CLKSEQ_INSTR_STEP_EN is defined.
module clock_sequencer #(
    parameter int DIV     = 4,
    parameter int DEB_MAX = 255,
    parameter int STEPS   = 5
) (
    input  logic       system_clock,
    input  logic       reset,
    input  logic       run_mode,
    input  logic       step_button,
    input  logic       instr_step,
    input  logic       step_end,
    input  logic       halt,
    output logic       clk_en,
    output logic [2:0] microstep,
    output logic       halted,
    output logic       busy
);

    // state   | meaning
    // IDLE    | manual mode, one tick per debounced press
    // RUN     | free-running prescaled ticks
    // ISTEP   | prescaled ticks until microstep wraps to 0
    // HALTED  | CPU executed HLT, frozen until reset
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_ISTEP  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [7:0] PRE_LAST  = 8'(DIV - 1);
    localparam logic [7:0] DEB_TOP   = 8'(DEB_MAX);
    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    state_t     state, state_next;
    logic [7:0] pre_cnt, pre_next;
    logic       tick;
    logic [7:0] deb_cnt;
    logic       deb_level, deb_level_q;
    logic       press;
    logic       ms_wrap;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            deb_cnt     <= 8'd0;
            deb_level   <= 1'b0;
            deb_level_q <= 1'b0;
        end else begin
            if (step_button && deb_cnt != DEB_TOP)
                deb_cnt <= deb_cnt + 8'd1;
            else if (!step_button && deb_cnt != 8'd0)
                deb_cnt <= deb_cnt - 8'd1;

            if (deb_cnt == DEB_TOP)
                deb_level <= 1'b1;
            else if (deb_cnt == 8'd0)
                deb_level <= 1'b0;

            deb_level_q <= deb_level;
        end
    end

    assign press   = deb_level & ~deb_level_q;
    assign ms_wrap = (microstep == LAST_STEP) || step_end;

    always_comb begin
        state_next = state;
        pre_next   = pre_cnt;
        tick       = 1'b0;
        case (state)
            S_IDLE: begin
                if (halt) begin
                    state_next = S_HALTED;
                end else if (run_mode) begin
                    state_next = S_RUN;
                    pre_next   = 8'd0;
                end else if (press) begin
`ifdef CLKSEQ_INSTR_STEP_EN
                    if (instr_step) begin
                        state_next = S_ISTEP;
                        pre_next   = 8'd0;
                    end else begin
                        tick = 1'b1;
                    end
`else
                    tick = 1'b1;
`endif
                end
            end
            S_RUN: begin
                if (halt) begin
                    state_next = S_HALTED;
                end else if (!run_mode) begin
                    state_next = S_IDLE;
                end else if (pre_cnt == PRE_LAST) begin
                    tick     = 1'b1;
                    pre_next = 8'd0;
                end else begin
                    pre_next = pre_cnt + 8'd1;
                end
            end
`ifdef CLKSEQ_INSTR_STEP_EN
            S_ISTEP: begin
                if (halt) begin
                    state_next = S_HALTED;
                end else if (run_mode) begin
                    state_next = S_RUN;
                    pre_next   = 8'd0;
                end else if (clk_en && ms_wrap) begin
                    // the wrapping tick is the one being delivered now
                    state_next = S_IDLE;
                end else if (pre_cnt == PRE_LAST) begin
                    tick     = 1'b1;
                    pre_next = 8'd0;
                end else begin
                    pre_next = pre_cnt + 8'd1;
                end
            end
`endif
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state     <= S_IDLE;
            pre_cnt   <= 8'd0;
            clk_en    <= 1'b0;
            microstep <= 3'd0;
            halted    <= 1'b0;
        end else begin
            state   <= state_next;
            pre_cnt <= pre_next;
            clk_en  <= tick;
            halted  <= (state_next == S_HALTED);
            // CPU samples the old microstep during clk_en; advance at its end
            if (clk_en)
                microstep <= ms_wrap ? 3'd0 : microstep + 3'd1;
        end
    end

`ifdef CLKSEQ_INSTR_STEP_EN
    always_ff @(posedge system_clock) begin
        if (reset)
            busy <= 1'b0;
        else
            busy <= (state_next == S_ISTEP);
    end
`else
    logic unused_instr_step;
    assign unused_instr_step = instr_step;
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer (DIV=4, DEB_MAX=255, STEPS=5).
// Instruction-step scenarios follow CLKSEQ_INSTR_STEP_EN like the design.
module tb_clock_sequencer;

    localparam int DIV     = 4;
    localparam int DEB_MAX = 255;
    localparam int STEPS   = 5;

    logic       system_clock = 1'b0;
    logic       reset, run_mode, step_button, instr_step, step_end, halt;
    logic       clk_en;
    logic [2:0] microstep;
    logic       halted, busy;

    int errors = 0;
    int checks = 0;

    clock_sequencer #(.DIV(DIV), .DEB_MAX(DEB_MAX), .STEPS(STEPS)) dut (
        .system_clock (system_clock),
        .reset        (reset),
        .run_mode     (run_mode),
        .step_button  (step_button),
        .instr_step   (instr_step),
        .step_end     (step_end),
        .halt         (halt),
        .clk_en       (clk_en),
        .microstep    (microstep),
        .halted       (halted),
        .busy         (busy)
    );

    always #5 system_clock = ~system_clock;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    // returns the negedge index at which clk_en is seen, -1 on timeout
    task automatic wait_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge system_clock);
            if (clk_en === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_ticks(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge system_clock);
            if (clk_en === 1'b1) cnt++;
        end
    endtask

    task automatic wait_ms(input logic [2:0] v, input int max, output int ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge system_clock);
            if (microstep === v) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_busy(input int max, output int ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge system_clock);
            if (busy === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset;
        @(negedge system_clock);
        reset       = 1'b1;
        run_mode    = 1'b0;
        step_button = 1'b0;
        instr_step  = 1'b0;
        step_end    = 1'b0;
        halt        = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        int n, c, tot, ok;

        // reset state
        do_reset();
        chk("rst_clk_en", clk_en, 0);
        chk("rst_microstep", microstep, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", busy, 0);

        // free run: tick every DIV cycles, microstep 0,1,2,3,4,0,1
        run_mode = 1'b1;
        wait_tick(20, n);
        chk("run_first_latency", n, 5);
        chk("run_ms_0", microstep, 0);
        for (int k = 1; k <= 6; k++) begin
            wait_tick(10, n);
            chk("run_gap", n, DIV);
            chk("run_ms_seq", microstep, k % STEPS);
        end
        run_mode = 1'b0;
        count_ticks(20, c);
        chk("run_off_no_ticks", c, 0);

        // clean press: DEB_MAX + 2 cycles to tick, old microstep seen with clk_en
        do_reset();
        step_button = 1'b1;
        wait_tick(400, n);
        chk("press_latency", n, DEB_MAX + 2);
        chk("press_ms_old", microstep, 0);
        cyc(1);
        chk("press_ms_new", microstep, 1);
        count_ticks(100, c);
        chk("press_held_no_more", c, 0);
        step_button = 1'b0;
        count_ticks(300, c);
        chk("press_release_no_tick", c, 0);

        // bouncing press then hold, bouncing release
        do_reset();
        tot = 0;
        for (int i = 0; i < 10; i++) begin
            step_button = (i % 2 == 0);
            count_ticks(1, c);
            tot += c;
        end
        step_button = 1'b1;
        count_ticks(300, c);
        tot += c;
        chk("bounce_press_ticks", tot, 1);
        chk("bounce_press_ms", microstep, 1);
        tot = 0;
        for (int i = 0; i < 10; i++) begin
            step_button = (i % 2 == 1);
            count_ticks(1, c);
            tot += c;
        end
        step_button = 1'b0;
        count_ticks(300, c);
        tot += c;
        chk("bounce_release_ticks", tot, 0);
        chk("bounce_release_ms", microstep, 1);

`ifdef CLKSEQ_INSTR_STEP_EN
        // one instruction: 5 ticks with busy high, back to IDLE at microstep 0
        do_reset();
        instr_step  = 1'b1;
        step_button = 1'b1;
        wait_busy(400, ok);
        chk("istep_busy_seen", ok, 1);
        step_button = 1'b0;
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge system_clock);
            if (clk_en === 1'b1) begin
                tot++;
                chk("istep_busy_at_tick", busy, 1);
            end
            if (busy !== 1'b1) break;
        end
        chk("istep_ticks", tot, STEPS);
        chk("istep_end_ms", microstep, 0);
        chk("istep_end_busy", busy, 0);
        count_ticks(30, c);
        chk("istep_idle_after", c, 0);

        // early end at microstep 2 stops the instruction after 3 ticks
        do_reset();
        instr_step  = 1'b1;
        step_button = 1'b1;
        wait_busy(400, ok);
        chk("istep_se_busy_seen", ok, 1);
        step_button = 1'b0;
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge system_clock);
            step_end = (microstep == 3'd2);
            if (clk_en === 1'b1) tot++;
            if (busy !== 1'b1) break;
        end
        step_end = 1'b0;
        chk("istep_se_ticks", tot, 3);
        chk("istep_se_ms", microstep, 0);
`else
        // without instruction stepping a press gives a single tick
        do_reset();
        instr_step  = 1'b1;
        step_button = 1'b1;
        count_ticks(300, c);
        chk("noistep_ticks", c, 1);
        chk("noistep_ms", microstep, 1);
        chk("noistep_busy", busy, 0);
`endif

        // step_end during RUN forces wrap from 2
        do_reset();
        run_mode = 1'b1;
        wait_ms(3'd2, 50, ok);
        chk("se_reach_2", ok, 1);
        step_end = 1'b1;
        wait_tick(10, n);
        chk("se_tick_ms", microstep, 2);
        cyc(1);
        step_end = 1'b0;
        chk("se_wrap", microstep, 0);
        wait_tick(10, n);
        cyc(1);
        chk("se_continue", microstep, 1);

        // halt at microstep 3 in RUN is sticky
        do_reset();
        run_mode = 1'b1;
        wait_ms(3'd3, 50, ok);
        chk("halt_reach_3", ok, 1);
        halt = 1'b1;
        cyc(1);
        chk("halt_flag", halted, 1);
        halt = 1'b0;
        tot = 0;
        for (int i = 0; i < 40; i++) begin
            run_mode = ((i / 4) % 2 == 0);
            count_ticks(1, c);
            tot += c;
        end
        chk("halt_no_ticks", tot, 0);
        chk("halt_still", halted, 1);
        chk("halt_ms_frozen", microstep, 3);
        do_reset();
        chk("halt_cleared", halted, 0);

        // reset mid-instruction while a tick is being decided
        do_reset();
`ifdef CLKSEQ_INSTR_STEP_EN
        instr_step  = 1'b1;
        step_button = 1'b1;
        wait_busy(400, ok);
        step_button = 1'b0;
`else
        run_mode = 1'b1;
`endif
        wait_ms(3'd3, 100, ok);
        chk("mid_reach_3", ok, 1);
        cyc(2);
        reset    = 1'b1;
        run_mode = 1'b0;
        cyc(1);
        chk("mid_rst_clk_en", clk_en, 0);
        chk("mid_rst_ms", microstep, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_halted", halted, 0);
        reset      = 1'b0;
        instr_step = 1'b0;
        count_ticks(30, c);
        chk("mid_rst_idle", c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
